// File: rtl/regfile_sb_if.sv
// ============================================================================
// Module      : regfile_sb_if
// Description : Bus bundle for regfile_sb. It carries the two read ports, the
//               busy query, the rd reservation at issue and the write-back
//               port. clk and rst_n are not part of this bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_sb_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 5
);
    logic              ready;
    logic [ADDR_W-1:0] rs1_addr;
    logic [ADDR_W-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              we;
    logic [ADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]   rd_data;

    // The register file side of the bundle.
    modport slave (
        output ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
        input  rs1_addr, rs2_addr, issue_valid, issue_rd, we, rd_addr, rd_data
    );

    // The decode/issue and write-back side of the bundle.
    modport master (
        input  ready, rs1_data, rs2_data, rs1_busy, rs2_busy,
        output rs1_addr, rs2_addr, issue_valid, issue_rd, we, rd_addr, rd_data
    );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// ============================================================================
// Module      : regfile_sb
// Description : Two-read/one-write integer register file for the pipelined
//               RV32 core. It clears every register in sequence after reset
//               and keeps a per-register pending-write scoreboard.
//               Optional macro REGFILE_BYPASS_EN enables write-to-read
//               forwarding. When the macro is defined, a read of the register
//               being written back returns rd_data and reports it not busy.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    regfile_sb_if.slave rf
);

    localparam int                NREGS      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] C_CNT_LAST = ADDR_W'(NREGS - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   regs_q [NREGS];

    logic [ADDR_W-1:0] w_rs_addr [2];
    logic [XLEN-1:0]   w_rs_data [2];
    logic              w_rs_busy [2];

    // Register 0 is wired to zero only when ZERO_REG is set.
    function automatic logic is_prot(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Sequence the clear, then track pending writes. A reservation overrides a
    // same-cycle retirement because the newer instruction owns the register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == C_CNT_LAST) begin
                state_d = ST_RUN;
            end
        end else begin
            if (rf.we && !is_prot(rf.rd_addr)) begin
                busy_d[rf.rd_addr] = 1'b0;
            end
            if (rf.issue_valid && !is_prot(rf.issue_rd)) begin
                busy_d[rf.issue_rd] = 1'b1;
            end
        end
    end

    // Control state and scoreboard are reset asynchronously. Reset forces a new clear pass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // The storage array has no reset. The clear pass writes zeros into it, and write-back is ignored until then.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            regs_q[cnt_q] <= '0;
        end else if (rf.we && !is_prot(rf.rd_addr)) begin
            regs_q[rf.rd_addr] <= rf.rd_data;
        end
    end

    assign w_rs_addr[0] = rf.rs1_addr;
    assign w_rs_addr[1] = rf.rs2_addr;

    // Combinational read ports. Both ports read zero and not busy until the clear pass finishes.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rs_data[p] = '0;
            w_rs_busy[p] = 1'b0;
            if ((state_q == ST_RUN) && !is_prot(w_rs_addr[p])) begin
`ifdef REGFILE_BYPASS_EN
                if (rf.we && (rf.rd_addr == w_rs_addr[p])) begin
                    w_rs_data[p] = rf.rd_data;
                    w_rs_busy[p] = 1'b0;
                end else begin
                    w_rs_data[p] = regs_q[w_rs_addr[p]];
                    w_rs_busy[p] = busy_q[w_rs_addr[p]];
                end
`else
                w_rs_data[p] = regs_q[w_rs_addr[p]];
                w_rs_busy[p] = busy_q[w_rs_addr[p]];
`endif
            end
        end
    end

    assign rf.rs1_data = w_rs_data[0];
    assign rf.rs2_data = w_rs_data[1];
    assign rf.rs1_busy = w_rs_busy[0];
    assign rf.rs2_busy = w_rs_busy[1];
    assign rf.ready    = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. It runs a ZERO_REG=1
//               instance and a ZERO_REG=0 instance side by side. Expected
//               values follow REGFILE_BYPASS_EN through BYP.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) rf1 ();
    regfile_sb_if #(.XLEN(32), .ADDR_W(5)) rf2 ();

    // The second instance receives the same stimulus as the first.
    assign rf2.rs1_addr    = rf1.rs1_addr;
    assign rf2.rs2_addr    = rf1.rs2_addr;
    assign rf2.issue_valid = rf1.issue_valid;
    assign rf2.issue_rd    = rf1.issue_rd;
    assign rf2.we          = rf1.we;
    assign rf2.rd_addr     = rf1.rd_addr;
    assign rf2.rd_data     = rf1.rd_data;

    regfile_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(1)) u_dut  (.clk(clk), .rst_n(rst_n), .rf(rf1));
    regfile_sb #(.XLEN(32), .ADDR_W(5), .ZERO_REG(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .rf(rf2));

    typedef struct {
        logic        we;
        logic [4:0]  rd_addr;
        logic [31:0] rd_data;
        logic        iv;
        logic [4:0]  issue_rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e1d; logic e1b;   // instance 1, port 1
        logic [31:0] e2d; logic e2b;   // instance 1, port 2
        logic [31:0] ezd; logic ezb;   // ZERO_REG=0 instance, port 1
    } vec_t;

    typedef struct {
        string       name;
        int          src;
        logic [32:0] exp;
    } sb_t;

    sb_t  sbq [$];
    vec_t tv  [$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Returns {busy, data} for a source. Source 3 returns ready in bit 0.
    function automatic logic [32:0] actual(input int src);
        case (src)
            0:       return {rf1.rs1_busy, rf1.rs1_data};
            1:       return {rf1.rs2_busy, rf1.rs2_data};
            2:       return {rf2.rs1_busy, rf2.rs1_data};
            default: return {32'd0, rf1.ready};
        endcase
    endfunction

    task automatic push(input string n, input int src, input logic b, input logic [31:0] d);
        sb_t s;
        s.name = n; s.src = src; s.exp = {b, d};
        sbq.push_back(s);
    endtask

    task automatic drain();
        sb_t s;
        logic [32:0] a;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            a = actual(s.src);
            n_cmp++;
            if (a !== s.exp) begin
                n_bad++;
                $display("FAIL %s: got busy=%0b data=0x%08h, want busy=%0b data=0x%08h",
                         s.name, a[32], a[31:0], s.exp[32], s.exp[31:0]);
            end
        end
    endtask

    task automatic drive(input logic we, input logic [4:0] ra, input logic [31:0] rdat,
                         input logic iv, input logic [4:0] ird,
                         input logic [4:0] r1, input logic [4:0] r2);
        rf1.we = we; rf1.rd_addr = ra; rf1.rd_data = rdat;
        rf1.issue_valid = iv; rf1.issue_rd = ird;
        rf1.rs1_addr = r1; rf1.rs2_addr = r2;
    endtask

    task automatic add(input logic we, input logic [4:0] ra, input logic [31:0] rdat,
                       input logic iv, input logic [4:0] ird,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] e1d, input logic e1b,
                       input logic [31:0] e2d, input logic e2b,
                       input logic [31:0] ezd, input logic ezb);
        vec_t v;
        v.we = we; v.rd_addr = ra; v.rd_data = rdat; v.iv = iv; v.issue_rd = ird;
        v.rs1 = r1; v.rs2 = r2;
        v.e1d = e1d; v.e1b = e1b; v.e2d = e2d; v.e2b = e2b; v.ezd = ezd; v.ezb = ezb;
        tv.push_back(v);
    endtask

    // Call this just after rst_n deasserts. It checks ready on each of the 32 clear edges and reads the ports mid-clear.
    task automatic clear_pass(input string tag);
        for (int e = 1; e <= 32; e++) begin
            @(posedge clk); #1;
            push($sformatf("%s_ready_e%0d", tag, e), 3, 1'b0, {31'd0, (e == 32)});
            if (e == 16) begin
                push($sformatf("%s_clr_rs1", tag), 0, 1'b0, 32'd0);
                push($sformatf("%s_clr_rs2", tag), 1, 1'b0, 32'd0);
                push($sformatf("%s_clr_z",   tag), 2, 1'b0, 32'd0);
            end
            drain();
        end
    endtask

    initial begin
        // Stimulus table for RUN. Each row is one cycle; expected values are sampled before that cycle's clock edge.
        //   we rd dat            iv ird rs1 rs2  e1 (data,busy)                 e2                 ez
        add(0, 0, 0,            1, 5,  5, 5,  0, 0,                           0, 0,             0, 0);
        add(0, 0, 0,            0, 0,  5, 6,  0, 1,                           0, 0,             0, 1);
        add(1, 5, 32'hDEADBEEF, 0, 0,  5, 3,  BYP ? 32'hDEADBEEF : 0, !BYP,   0, 0,             BYP ? 32'hDEADBEEF : 0, !BYP);
        add(0, 0, 0,            0, 0,  5, 5,  32'hDEADBEEF, 0,                32'hDEADBEEF, 0,  32'hDEADBEEF, 0);
        add(1, 7, 32'h12,       1, 7,  7, 7,  BYP ? 32'h12 : 0, 0,            BYP ? 32'h12 : 0, 0, BYP ? 32'h12 : 0, 0);
        add(0, 0, 0,            0, 0,  0, 7,  0, 0,                           32'h12, 1,        0, 0);
        add(0, 0, 0,            1, 0,  0, 0,  0, 0,                           0, 0,             0, 0);
        add(1, 0, 32'hFFFFFFFF, 0, 0,  0, 0,  0, 0,                           0, 0,             BYP ? 32'hFFFFFFFF : 0, !BYP);
        add(0, 0, 0,            0, 0,  0, 0,  0, 0,                           0, 0,             32'hFFFFFFFF, 0);
        add(1, 3, 32'hA5A5A5A5, 0, 0,  3, 4,  BYP ? 32'hA5A5A5A5 : 0, 0,      0, 0,             BYP ? 32'hA5A5A5A5 : 0, 0);
        add(0, 0, 0,            1, 7,  3, 7,  32'hA5A5A5A5, 0,                32'h12, 1,        32'hA5A5A5A5, 0);
        add(0, 0, 0,            1, 4,  7, 4,  32'h12, 1,                      0, 0,             32'h12, 1);
        add(0, 0, 0,            0, 0,  4, 7,  0, 1,                           32'h12, 1,        0, 1);

        // Power-on reset. Drive rst_n high first so the assertion is a real falling edge.
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push("por_ready", 3, 1'b0, 32'd0);
        push("por_rs1",   0, 1'b0, 32'd0);
        push("por_rs2",   1, 1'b0, 32'd0);
        drain();
        rst_n = 1'b1;
        clear_pass("por");
        drive(0, 0, 0, 0, 0, 31, 1);
        #1;
        push("run_rs1_x31", 0, 1'b0, 32'd0);
        push("run_rs2_x1",  1, 1'b0, 32'd0);
        drain();
        @(posedge clk); #1;

        // Table-driven RUN sequence.
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].we, tv[i].rd_addr, tv[i].rd_data, tv[i].iv, tv[i].issue_rd,
                  tv[i].rs1, tv[i].rs2);
            #1;
            push($sformatf("v%0d_rs1", i),  0, tv[i].e1b, tv[i].e1d);
            push($sformatf("v%0d_rs2", i),  1, tv[i].e2b, tv[i].e2d);
            push($sformatf("v%0d_z_rs1", i), 2, tv[i].ezb, tv[i].ezd);
            drain();
            @(posedge clk); #1;
        end

        // Assert reset mid-run. Ready and all outputs must drop at once.
        drive(0, 0, 0, 0, 0, 3, 4);
        #1;
        push("pre_rst_x3", 0, 1'b0, 32'hA5A5A5A5);
        push("pre_rst_x4", 1, 1'b1, 32'd0);
        drain();
        #2 rst_n = 1'b0;
        #1;
        push("rst_ready", 3, 1'b0, 32'd0);
        push("rst_x3",    0, 1'b0, 32'd0);
        push("rst_x4",    1, 1'b0, 32'd0);
        push("rst_z_x3",  2, 1'b0, 32'd0);
        drain();

        // Drive writes and issues to x9 throughout the second clear pass. They must have no effect.
        drive(1, 9, 32'h55, 1, 9, 9, 9);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_pass("rerun");
        drive(0, 0, 0, 0, 0, 3, 4);
        #1;
        push("post_x3", 0, 1'b0, 32'd0);
        push("post_x4", 1, 1'b0, 32'd0);
        drain();
        drive(0, 0, 0, 0, 0, 9, 9);
        #1;
        push("post_x9_p1", 0, 1'b0, 32'd0);
        push("post_x9_p2", 1, 1'b0, 32'd0);
        push("post_z_x9",  2, 1'b0, 32'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
